// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk_in cycles
`timescale 1ns/10ps
module pwm_capture #(
  parameter int COUNTER_WIDTH = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     pwm_in,
  output logic [COUNTER_WIDTH-1:0] period_out,
  output logic [COUNTER_WIDTH-1:0] high_out,
  output logic                     valid_out,
  output logic                     overflow_out,
  output logic                     level_out
);
  typedef enum logic [1:0] {WAIT_EDGE, HIGH, LOW} state_t;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev_q, rise, fall, sat, valid_d, overflow_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, high_cap_q, high_cap_d, period_d, high_d;
  assign level_out = sync_q[SYNC_STAGES-1];
  assign rise      = level_out & ~prev_q;
  assign fall      = ~level_out & prev_q;
  assign sat       = cnt_q == CNT_MAX;
  assign cnt_inc   = sat ? cnt_q : cnt_q + CNT_ONE;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= level_out;
    end
  end
  // an edge on the saturation cycle wins over overflow
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    period_d   = period_out;
    high_d     = high_out;
    valid_d    = 1'b0;
    overflow_d = overflow_out;
    case (state_q)
      WAIT_EDGE: if (rise) begin
        state_d = HIGH;
        cnt_d   = CNT_ONE;
      end
      HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          high_cap_d = cnt_q;
          state_d    = LOW;
        end else if (sat) begin
          state_d    = WAIT_EDGE;
          overflow_d = 1'b1;
        end
      end
      LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          period_d   = cnt_q;
          high_d     = high_cap_q;
          valid_d    = 1'b1;
          overflow_d = 1'b0;
          cnt_d      = CNT_ONE;
          state_d    = HIGH;
        end else if (sat) begin
          state_d    = WAIT_EDGE;
          overflow_d = 1'b1;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= WAIT_EDGE;
      cnt_q        <= '0;
      high_cap_q   <= '0;
      period_out   <= '0;
      high_out     <= '0;
      valid_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_cap_q   <= high_cap_d;
      period_out   <= period_d;
      high_out     <= high_d;
      valid_out    <= valid_d;
      overflow_out <= overflow_d;
    end
  end
endmodule
